// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and state type for the host-side uart TX buffer.
package uart_tx_fifo_pkg;

  localparam logic [7:0] UART_STS_OFF  = 8'h04;
  localparam logic [7:0] UART_TXD_OFF  = 8'h0C;

  localparam logic [7:0] HOST_PUSH_OFF = 8'h00;
  localparam logic [7:0] HOST_STAT_OFF = 8'h04;
  localparam logic [7:0] HOST_CTRL_OFF = 8'h08;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_POLL,
    TXF_GAP,
    TXF_WRITE
  } txf_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with same-cycle push/pop and synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Host TX buffer: CPU pushes bytes, the FSM polls uart status and writes each
// byte to the uart TX data register as bus master.
//
// state     | meaning
// TXF_IDLE  | nothing in flight; leave when the FIFO holds a byte
// TXF_POLL  | reading uart status, waiting for uart_ready_i
// TXF_GAP   | uart was busy; back off GAP_CYC cycles with req low
// TXF_WRITE | writing the latched head byte to uart TXD until accepted
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] UART_STS = UART_STS_OFF,
  parameter logic [7:0] UART_TXD = UART_TXD_OFF,
  parameter int         GAP_CYC  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic        uart_req_o,
  output logic        uart_we_o,
  output logic [31:0] uart_addr_o,
  output logic [31:0] uart_data_o,
  input  logic        uart_ready_i,
  input  logic [31:0] uart_data_i
);

  localparam int AW    = $clog2(DEPTH);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  txf_state_e       state;
  logic [GAP_W-1:0] gap_cnt;
  logic             flushed_q;
  logic             ovf;

  logic [7:0]       host_off;
  logic             wr_push;
  logic             wr_ctrl;
  logic             rd_stat;
  logic             flush;

  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  logic             unused_ok;
  assign unused_ok = ^{addr_i[31:8], data_i[31:8], uart_data_i[31:1]};

  assign host_off = addr_i[7:0];
  assign wr_push  = req_i && we_i  && (host_off == HOST_PUSH_OFF);
  assign wr_ctrl  = req_i && we_i  && (host_off == HOST_CTRL_OFF);
  assign rd_stat  = req_i && !we_i && (host_off == HOST_STAT_OFF);
  assign flush    = wr_ctrl && data_i[0];
  assign ready_o  = req_i;

  always_comb begin
    data_o = '0;
    if (rd_stat) data_o = {16'h0, 8'(fifo_count), 5'h0, ovf, fifo_full, fifo_empty};
  end

  // a flush seen during WRITE means the byte on the bus is no longer the head
  assign fifo_pop = (state == TXF_WRITE) && uart_ready_i && !flushed_q && !flush;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (wr_push),
    .pop    (fifo_pop),
    .flush  (flush),
    .wdata  (data_i[7:0]),
    .head   (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf <= 1'b0;
    end else if (wr_ctrl && data_i[1]) begin
      ovf <= 1'b0;
    end else if (wr_push && fifo_full && !fifo_pop) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= TXF_IDLE;
      gap_cnt     <= '0;
      flushed_q   <= 1'b0;
      uart_req_o  <= 1'b0;
      uart_we_o   <= 1'b0;
      uart_addr_o <= '0;
      uart_data_o <= '0;
    end else begin
      case (state)
        TXF_IDLE: begin
          if (!fifo_empty && !flush) begin
            state       <= TXF_POLL;
            uart_req_o  <= 1'b1;
            uart_we_o   <= 1'b0;
            uart_addr_o <= {24'h0, UART_STS};
          end
        end
        TXF_POLL: begin
          if (flush) begin
            state       <= TXF_IDLE;
            uart_req_o  <= 1'b0;
            uart_addr_o <= '0;
          end else if (uart_ready_i) begin
            if (uart_data_i[0]) begin
              state       <= TXF_GAP;
              gap_cnt     <= GAP_W'(GAP_CYC - 1);
              uart_req_o  <= 1'b0;
              uart_addr_o <= '0;
            end else begin
              state       <= TXF_WRITE;
              flushed_q   <= 1'b0;
              uart_we_o   <= 1'b1;
              uart_addr_o <= {24'h0, UART_TXD};
              uart_data_o <= {24'h0, fifo_head};
            end
          end
        end
        TXF_GAP: begin
          if (flush) begin
            state <= TXF_IDLE;
          end else if (gap_cnt == '0) begin
            state       <= TXF_POLL;
            uart_req_o  <= 1'b1;
            uart_we_o   <= 1'b0;
            uart_addr_o <= {24'h0, UART_STS};
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        TXF_WRITE: begin
          if (flush) flushed_q <= 1'b1;
          if (uart_ready_i) begin
            state       <= TXF_IDLE;
            flushed_q   <= 1'b0;
            uart_req_o  <= 1'b0;
            uart_we_o   <= 1'b0;
            uart_addr_o <= '0;
            uart_data_o <= '0;
          end
        end
        default: begin
          state      <= TXF_IDLE;
          uart_req_o <= 1'b0;
          uart_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
